// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and defaults.
// The state codes match the ones used across the edge-detector family so
// waveform decoders and debug scripts can be reused unchanged.
package pulse_stretch_pkg;

  // Controller states; the 2-bit codes are fixed and shared with sibling blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  // Default counter width and minimum low gap after each pulse.
  localparam int CNT_W_DEFAULT   = 8;
  localparam int GAP_CYC_DEFAULT = 2;

endpackage : pulse_stretch_pkg

// File: rtl/pulse_stretch_load_down_counter.sv
// Loadable down counter with a registered zero flag.
// The zero flag is computed from the value being written rather than from the
// counter output, so it is valid in the same cycle as the count and the FSM
// never needs a comparator on the count itself.
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg;
  logic             zero_reg;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg  <= '0;
      zero_reg <= 1'b1;
    end else if (load) begin
      cnt_reg  <= load_val;
      zero_reg <= (load_val == '0);
    end else if (dec && !zero_reg) begin
      cnt_reg  <= cnt_reg - ONE;
      zero_reg <= (cnt_reg == ONE);
    end
  end

  assign zero = zero_reg;

endmodule : load_down_counter

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns a single-cycle tick into a level pulse of len cycles
// (len==0 counts as 1), then holds a minimum low gap of GAP_CYC cycles.
// Ticks that cannot be honoured (during the gap, or during the pulse when
// retrigger is off) are flagged on drop one cycle later.
// level, busy and drop all come straight from flops.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int GAP_CYC = GAP_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] len,
  input  logic             retrig,
  output logic             level,
  output logic             busy,
  output logic             drop
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               HAS_GAP  = (GAP_CYC > 0);
  // Gap counter preload; unused when there is no gap.
  localparam logic [CNT_W-1:0] GAP_LOAD = HAS_GAP ? CNT_W'(GAP_CYC - 1) : '0;

  state_e           state_reg;
  logic             level_reg;
  logic             busy_reg;
  logic             drop_reg;

  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] len_m1;
  logic             accept;
  logic             ignored;
  logic             leave_high;

  // Counter control and tick classification for the current state.
  always_comb begin
    accept       = 1'b0;
    ignored      = 1'b0;
    leave_high   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = GAP_LOAD;
    cnt_dec      = 1'b0;
    // Counter holds L-1: a len of 0 or 1 both give a single-cycle pulse.
    len_m1       = (len == '0) ? '0 : (len - ONE);

    unique case (state_reg)
      ST_IDLE: accept = tick;
      ST_HIGH: begin
        accept  = tick && retrig;
        ignored = tick && !retrig;
      end
      ST_GAP:  ignored = tick;
      default: ;
    endcase

    leave_high = (state_reg == ST_HIGH) && !accept && cnt_zero;

    if (accept) begin
      cnt_load     = 1'b1;
      cnt_load_val = len_m1;
    end else if (leave_high && HAS_GAP) begin
      cnt_load     = 1'b1;
      cnt_load_val = GAP_LOAD;
    end

    cnt_dec = (state_reg != ST_IDLE) && !cnt_load;
  end

  load_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Controller FSM with registered level/busy/drop outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      level_reg <= 1'b0;
      busy_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      drop_reg <= ignored;
      unique case (state_reg)
        ST_IDLE: begin
          if (tick) begin
            state_reg <= ST_HIGH;
            level_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        ST_HIGH: begin
          // A retrigger reloads the counter and keeps level high without a glitch.
          if (!accept && cnt_zero) begin
            level_reg <= 1'b0;
            if (HAS_GAP) begin
              state_reg <= ST_GAP;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          level_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_reg;
  assign busy  = busy_reg;
  assign drop  = drop_reg;

endmodule : pulse_stretch
